// File: rtl/vec_capture_buf.sv
// -----------------------------------------------------------------------------
// vec_capture_buf
//
// Watches the 4-bit vector {A,B,D,E} of a small combinational DUT and records
// every change together with a saturating cycle timestamp. The trace is held
// in a first-word-fall-through FIFO and drained through a valid/ready port.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   arm_i        start capture (honoured in IDLE only, flushes the FIFO)
//   stop_i       end capture (honoured in CAPTURE only)
//   A_i..E_i     observed DUT nets, sampled directly at each rising edge
//   rd_valid_o   head entry available
//   rd_ready_i   consumer accepts the head entry
//   rd_data_o    head vector {A,B,D,E}, 0 when empty
//   rd_stamp_o   head timestamp, 0 when empty
//   count_o      entries held
//   full_o       count_o == DEPTH
//   overflow_o   sticky: a change was dropped since the last arm
//   busy_o       capture state machine is not IDLE
// -----------------------------------------------------------------------------
module vec_capture_buf #(
   parameter int DEPTH   = 8,
   parameter int STAMP_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     arm_i,
   input  logic                     stop_i,
   input  logic                     A_i,
   input  logic                     B_i,
   input  logic                     D_i,
   input  logic                     E_i,
   output logic                     rd_valid_o,
   input  logic                     rd_ready_i,
   output logic [3:0]               rd_data_o,
   output logic [STAMP_W-1:0]       rd_stamp_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     overflow_o,
   output logic                     busy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [STAMP_W-1:0] STAMP_MAX = {STAMP_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t               state_r;
   logic [STAMP_W-1:0]   stamp_r;
   logic [3:0]           last_r;
   logic [PW-1:0]        wr_ptr_r;
   logic [PW-1:0]        rd_ptr_r;
   logic [CW-1:0]        count_r;
   logic                 full_r;
   logic                 overflow_r;
   logic                 busy_r;
   logic                 head_valid_r;
   logic [3:0]           head_data_r;
   logic [STAMP_W-1:0]   head_stamp_r;

   logic [3:0]           mem_data_r  [DEPTH];
   logic [STAMP_W-1:0]   mem_stamp_r [DEPTH];

   logic [3:0]           vec_s;
   logic                 push_req_s;
   logic [STAMP_W-1:0]   push_stamp_s;
   logic                 pop_s;
   logic                 push_ok_s;
   logic                 drop_s;
   logic [CW-1:0]        count_nxt_s;
   logic [PW-1:0]        rd_ptr_inc_s;
   logic [3:0]           head_data_nxt_s;
   logic [STAMP_W-1:0]   head_stamp_nxt_s;

   assign vec_s = {A_i, B_i, D_i, E_i};

   // Push request: baseline in ARMED, changes in CAPTURE (stop suppresses).
   always_comb begin
      push_req_s   = 1'b0;
      push_stamp_s = stamp_r;
      case (state_r)
         ST_ARMED: begin
            push_req_s   = 1'b1;
            push_stamp_s = {STAMP_W{1'b0}};
         end
         ST_CAPTURE: begin
            if (!stop_i && (vec_s != last_r)) begin
               push_req_s = 1'b1;
            end else begin
               push_req_s = 1'b0;
            end
         end
         default: begin
            push_req_s = 1'b0;
         end
      endcase
   end

   // FIFO bookkeeping and next head entry, so the read port stays registered.
   always_comb begin
      pop_s            = head_valid_r && rd_ready_i;
      push_ok_s        = push_req_s && (!full_r || pop_s);
      drop_s           = push_req_s && full_r && !pop_s;
      count_nxt_s      = count_r + CW'(push_ok_s) - CW'(pop_s);
      rd_ptr_inc_s     = rd_ptr_r + PW'(1);
      head_data_nxt_s  = 4'd0;
      head_stamp_nxt_s = {STAMP_W{1'b0}};
      if (count_nxt_s == {CW{1'b0}}) begin
         head_data_nxt_s  = 4'd0;
         head_stamp_nxt_s = {STAMP_W{1'b0}};
      end else if (push_ok_s && ((count_r == {CW{1'b0}}) ||
                                 (pop_s && (count_r == CW'(1))))) begin
         // The pushed entry becomes the only entry: forward it directly.
         head_data_nxt_s  = vec_s;
         head_stamp_nxt_s = push_stamp_s;
      end else if (pop_s) begin
         head_data_nxt_s  = mem_data_r[rd_ptr_inc_s];
         head_stamp_nxt_s = mem_stamp_r[rd_ptr_inc_s];
      end else begin
         head_data_nxt_s  = mem_data_r[rd_ptr_r];
         head_stamp_nxt_s = mem_stamp_r[rd_ptr_r];
      end
   end

   // Storage array write; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_data_r[wr_ptr_r]  <= vec_s;
         mem_stamp_r[wr_ptr_r] <= push_stamp_s;
      end
   end

   // Capture state machine, FIFO pointers and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         stamp_r      <= {STAMP_W{1'b0}};
         last_r       <= 4'd0;
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         full_r       <= 1'b0;
         overflow_r   <= 1'b0;
         busy_r       <= 1'b0;
         head_valid_r <= 1'b0;
         head_data_r  <= 4'd0;
         head_stamp_r <= {STAMP_W{1'b0}};
      end else if ((state_r == ST_IDLE) && arm_i) begin
         // Arm flushes the FIFO; any same-edge read is discarded with it.
         state_r      <= ST_ARMED;
         stamp_r      <= {STAMP_W{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         full_r       <= 1'b0;
         overflow_r   <= 1'b0;
         busy_r       <= 1'b1;
         head_valid_r <= 1'b0;
         head_data_r  <= 4'd0;
         head_stamp_r <= {STAMP_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_inc_s;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r      <= count_nxt_s;
         full_r       <= (count_nxt_s == CW'(DEPTH));
         overflow_r   <= overflow_r || drop_s;
         head_valid_r <= (count_nxt_s != {CW{1'b0}});
         head_data_r  <= head_data_nxt_s;
         head_stamp_r <= head_stamp_nxt_s;
         case (state_r)
            ST_ARMED: begin
               state_r <= ST_CAPTURE;
               last_r  <= vec_s;
               stamp_r <= STAMP_W'(1);
               busy_r  <= 1'b1;
            end
            ST_CAPTURE: begin
               last_r <= vec_s;
               if (stamp_r != STAMP_MAX) begin
                  stamp_r <= stamp_r + STAMP_W'(1);
               end else begin
                  stamp_r <= stamp_r;
               end
               if (stop_i) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_CAPTURE;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_valid_o = head_valid_r;
   assign rd_data_o  = head_data_r;
   assign rd_stamp_o = head_stamp_r;
   assign count_o    = count_r;
   assign full_o     = full_r;
   assign overflow_o = overflow_r;
   assign busy_o     = busy_r;

endmodule

// File: tb/tb_vec_capture_buf.sv
// -----------------------------------------------------------------------------
// tb_vec_capture_buf
//
// Directed bench for vec_capture_buf (DEPTH=8, STAMP_W=8). Inputs change after
// a short delay past each rising edge; outputs are sampled 1 time unit after
// the edge. Expected values are hand-computed from the capture rules.
// -----------------------------------------------------------------------------
module tb_vec_capture_buf;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       arm_i = 1'b0;
   logic       stop_i = 1'b0;
   logic       A_i = 1'b0;
   logic       B_i = 1'b0;
   logic       D_i = 1'b0;
   logic       E_i = 1'b0;
   logic       rd_valid_o;
   logic       rd_ready_i = 1'b0;
   logic [3:0] rd_data_o;
   logic [7:0] rd_stamp_o;
   logic [3:0] count_o;
   logic       full_o;
   logic       overflow_o;
   logic       busy_o;

   int checks_s   = 0;
   int failures_s = 0;

   vec_capture_buf #(.DEPTH(8), .STAMP_W(8)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .arm_i      (arm_i),
      .stop_i     (stop_i),
      .A_i        (A_i),
      .B_i        (B_i),
      .D_i        (D_i),
      .E_i        (E_i),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready_i),
      .rd_data_o  (rd_data_o),
      .rd_stamp_o (rd_stamp_o),
      .count_o    (count_o),
      .full_o     (full_o),
      .overflow_o (overflow_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_s = checks_s + 1;
      if (got !== exp) begin
         failures_s = failures_s + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge, then settle so outputs can be sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_v(input logic [3:0] v);
      {A_i, B_i, D_i, E_i} = v;
   endtask

   // Arm from IDLE with vector v; returns after the ARMED edge (baseline pushed).
   task automatic arm_with(input logic [3:0] v);
      set_v(v);
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      tick();
   endtask

   task automatic pop_expect(input string tag, input logic [3:0] d, input logic [7:0] s);
      check_val({tag, "_valid"}, rd_valid_o, 1);
      check_val({tag, "_data"},  rd_data_o,  d);
      check_val({tag, "_stamp"}, rd_stamp_o, s);
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
   endtask

   logic [3:0] walk [7];
   int         busy_cnt;

   initial begin
      walk[0] = 4'b0000; walk[1] = 4'b1000; walk[2] = 4'b1100; walk[3] = 4'b1110;
      walk[4] = 4'b0100; walk[5] = 4'b0110; walk[6] = 4'b0010;

      // ---------------- reset state ----------------
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      check_val("rst_valid", rd_valid_o, 0);
      check_val("rst_data",  rd_data_o,  0);
      check_val("rst_stamp", rd_stamp_o, 0);
      check_val("rst_count", count_o,    0);
      check_val("rst_full",  full_o,     0);
      check_val("rst_ovf",   overflow_o, 0);
      check_val("rst_busy",  busy_o,     0);

      // ---------------- constant vector: one baseline entry ----------------
      set_v(4'b0000);
      arm_i = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) stop_i = 1'b1;
         tick();
         arm_i  = 1'b0;
         stop_i = 1'b0;
         if (busy_o) busy_cnt = busy_cnt + 1;
      end
      check_val("t1_busy_cycles", busy_cnt, 4);
      check_val("t1_busy_after",  busy_o,   0);
      check_val("t1_count",       count_o,  1);
      pop_expect("t1_e0", 4'b0000, 8'd0);
      check_val("t1_empty", rd_valid_o, 0);

      // ---------------- truth-table walk, change every 5 cycles ----------------
      arm_with(walk[0]);
      for (int k = 1; k < 7; k++) begin
         repeat (4) tick();
         set_v(walk[k]);
         tick();
         check_val("t2_head_stable", rd_data_o, 4'b0000);
      end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check_val("t2_count", count_o,    7);
      check_val("t2_full",  full_o,     0);
      check_val("t2_ovf",   overflow_o, 0);
      for (int k = 0; k < 7; k++) begin
         pop_expect($sformatf("t2_e%0d", k), walk[k], 8'(5 * k));
      end
      check_val("t2_count_end", count_o, 0);

      // ---------------- overflow with 10 changes ----------------
      arm_with(4'd0);
      for (int k = 1; k <= 10; k++) begin
         set_v(4'(k));
         tick();
      end
      check_val("t3_count", count_o,    8);
      check_val("t3_full",  full_o,     1);
      check_val("t3_ovf",   overflow_o, 1);
      check_val("t3_head",  rd_data_o,  0);

      // Full FIFO: pop and push on the same edge.
      set_v(4'd11);
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
      check_val("t4_count", count_o,    8);
      check_val("t4_full",  full_o,     1);
      check_val("t4_ovf",   overflow_o, 1);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         pop_expect($sformatf("t4_e%0d", k), 4'(k), 8'(k));
      end
      pop_expect("t4_new", 4'd11, 8'd11);
      check_val("t4_empty", rd_valid_o, 0);

      // ---------------- stamp saturation and stop priority ----------------
      arm_with(4'b0000);
      repeat (300) tick();
      set_v(4'b0001);
      tick();
      check_val("t5_count", count_o, 2);
      set_v(4'b0000);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check_val("t5_stop_count", count_o, 2);
      check_val("t5_stop_busy",  busy_o,  0);
      pop_expect("t5_e0", 4'b0000, 8'd0);
      pop_expect("t5_e1", 4'b0001, 8'd255);
      check_val("t5_empty", rd_valid_o, 0);

      // ---------------- arm ignored in CAPTURE, then reset mid-capture ----------------
      arm_with(4'd0);
      for (int k = 1; k <= 3; k++) begin
         set_v(4'(k));
         tick();
      end
      check_val("t6_count4", count_o, 4);
      set_v(4'd4);
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      check_val("t6_count5", count_o, 5);
      check_val("t6_busy",   busy_o,  1);
      check_val("t6_head",   rd_data_o, 0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_val("t6_rst_count", count_o,    0);
      check_val("t6_rst_valid", rd_valid_o, 0);
      check_val("t6_rst_busy",  busy_o,     0);
      check_val("t6_rst_ovf",   overflow_o, 0);
      check_val("t6_rst_data",  rd_data_o,  0);
      check_val("t6_rst_stamp", rd_stamp_o, 0);
      set_v(4'd9);
      tick();
      check_val("t6_idle_count", count_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
      $finish;
   end

endmodule

// File: doc/vec_capture_buf.md
# vec_capture_buf

Synchronous capture buffer that watches the stimulus/response nets of a small combinational DUT (three inputs A, B, D and one output E) and records every change of the 4-bit vector with a cycle timestamp. It is the receiving end of the stimulus sequence a bench or on-chip pattern driver applies. The captured trace drains through a valid/ready read port, so a checker or host can compare it against the expected truth-table walk. One instance sits beside each DUT under observation.

## Interface
- DEPTH, 8, number of FIFO entries; power of two, >= 2
- STAMP_W, 8, timestamp width; saturating
- clk_i  input  1  rising-edge clock
- rst_i  input  1  reset; one clock, reset is synchronous and active-high
- arm_i  input  1  start-capture request; acted on only in IDLE
- stop_i  input  1  end-capture request; acted on only in CAPTURE
- A_i  input  1  observed DUT input A
- B_i  input  1  observed DUT input B
- D_i  input  1  observed DUT input D
- E_i  input  1  observed DUT output E
- rd_valid_o  output  1  head entry available
- rd_ready_i  input  1  consumer accepts head entry
- rd_data_o  output  4  head vector {A,B,D,E}; 0 when empty
- rd_stamp_o  output  STAMP_W  head timestamp; 0 when empty
- count_o  output  $clog2(DEPTH)+1  entries held
- full_o  output  1  count_o == DEPTH
- overflow_o  output  1  sticky: a change was dropped since last arm
- busy_o  output  1  state != IDLE

## Operation
- Vector v = {A_i,B_i,D_i,E_i}, sampled directly at each rising edge; no input pipeline.
- States: IDLE, ARMED, CAPTURE.
- IDLE: arm_i=1 -> ARMED; same edge flushes FIFO (count 0), clears overflow_o, stamp <= 0. Reads are allowed in IDLE (drain after stop).
- ARMED (exactly one cycle): unconditionally push {v, stamp=0}; last_q <= v; stamp <= 1; -> CAPTURE.
- CAPTURE, each edge: stop_i=1 -> IDLE, no push (stop wins over a simultaneous change). Else if v != last_q -> push {v, stamp}. Always last_q <= v; stamp <= min(stamp+1, 2^STAMP_W-1).
- arm_i outside IDLE and stop_i outside CAPTURE are ignored.
- FIFO: first-word-fall-through; pop when rd_valid_o && rd_ready_i.
- Push while full: accepted only if a pop occurs the same edge (count unchanged); otherwise dropped and overflow_o <= 1 (sticky until next arm or reset). last_q still updates on a dropped push.
- Push and pop same edge, not full: count unchanged, both happen.
- Stamp saturates at 255 (STAMP_W=8) and never wraps; later entries carry 255.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.

## Timing
- Reset values: rd_valid_o 0, rd_data_o 0, rd_stamp_o 0, count_o 0, full_o 0, overflow_o 0, busy_o 0; state IDLE, stamp 0, last_q 0.
- rst_i mid-capture: all state cleared at that edge and buffered entries are lost; outputs at reset values the next cycle.
- Push latency: a vector sampled at edge k is visible on rd_data_o/rd_valid_o after edge k (when the FIFO was empty), i.e. in the cycle following k.
- count_o, full_o, overflow_o, busy_o are registered and update on the same edge as the event.
- Back-to-back pops sustain 1 entry/cycle; rd_data_o is stable while rd_valid_o && !rd_ready_i.
- busy_o rises the cycle after the arm edge and falls the cycle after the stop edge.

## Test plan
- Reset then arm with v=0000, hold 3 cycles, stop -> exactly one entry {0000, stamp 0}; count_o=1; busy_o 1 for 4 cycles.
- Arm, then apply 0000,1000,1100,1110,0100,0110,0010, changing every 5 cycles (rd_ready_i=0) -> 7 entries with stamps 0,5,10,15,20,25,30; full_o=0, overflow_o=0; drain yields them in order.
- DEPTH=8, rd_ready_i=0, 10 distinct changes after arm -> count_o=8, full_o=1, overflow_o=1; entries are baseline plus the first 7 changes.
- Full FIFO, rd_ready_i=1 on the same edge as a change -> pop and push both occur, count_o stays 8, overflow_o unchanged.
- Hold v constant for 300 cycles, then toggle E_i -> new entry stamp 255; stop_i on the same edge as a change -> no entry, state IDLE.
- Assert rst_i mid-capture with 4 entries buffered -> next cycle count_o=0, rd_valid_o=0, busy_o=0, overflow_o=0; arm_i during CAPTURE -> no flush, capture continues.
